// File: rtl/pipeline_hazard_ctrl_if.sv
// Issue-control bundle between the DOF stage decode and the hazard controller.
// Carries the DOF instruction fields, the EX branch outcome, the counter clear,
// and the pipeline enables, stall/flush indications and performance counters.
//   master : decode/datapath side (drives instruction fields, reads controls)
//   slave  : pipeline_hazard_ctrl
interface pipeline_hazard_ctrl_if;
  logic       in_valid;
  logic [2:0] AA;
  logic [2:0] BA;
  logic [2:0] DA;
  logic       RW;
  logic       MA;
  logic       MB;
  logic [1:0] BS;
  logic       br_taken;
  logic       clr_cnt;

  logic       pc_en;
  logic       ir_en;
  logic       bubble;
  logic       flush;
  logic       DHS;
  logic [1:0] state;
  logic [7:0] stall_cnt;
  logic [7:0] flush_cnt;

  modport master (
    output in_valid, AA, BA, DA, RW, MA, MB, BS, br_taken, clr_cnt,
    input  pc_en, ir_en, bubble, flush, DHS, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, AA, BA, DA, RW, MA, MB, BS, br_taken, clr_cnt,
    output pc_en, ir_en, bubble, flush, DHS, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Issue controller for the 4-stage IF/DOF/EX/WB pipeline of the 8-register
// datapath. Tracks EX/WB destinations, stalls DOF on read-after-write hazards,
// resolves predict-not-taken branches one cycle after issue, and counts
// stall and flush cycles (saturating at 255).
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : pipeline_hazard_ctrl_if.slave (instruction fields in, controls out)
//
// state  | meaning
// RUN    | normal issue, no branch awaiting resolution
// STALL  | previous cycle stalled DOF on a data hazard
// BRANCH | a branch issued last cycle; br_taken is evaluated now
module pipeline_hazard_ctrl (
  input  logic                   clk,
  input  logic                   reset_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_BRANCH = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic       ex_v;
  logic [2:0] ex_d;
  logic       wb_v;
  logic [2:0] wb_d;

  logic [7:0] stall_cnt_q;
  logic [7:0] flush_cnt_q;

  logic hz_a;
  logic hz_b;
  logic kill;
  logic haz;

  assign kill = (state_q == ST_BRANCH) & bus.br_taken;

  assign hz_a = ~bus.MA & ((ex_v & (bus.AA == ex_d)) | (wb_v & (bus.AA == wb_d)));
  assign hz_b = ~bus.MB & ((ex_v & (bus.BA == ex_d)) | (wb_v & (bus.BA == wb_d)));

  // A taken branch discards the DOF instruction, so its hazard is irrelevant.
  assign haz = bus.in_valid & (hz_a | hz_b) & ~kill;

  always_comb begin
    bus.pc_en  = 1'b1;
    bus.ir_en  = 1'b1;
    bus.bubble = 1'b0;
    bus.flush  = 1'b0;
    bus.DHS    = 1'b1;
    if (kill) begin
      bus.flush  = 1'b1;
      bus.bubble = 1'b1;
    end else if (haz) begin
      bus.pc_en  = 1'b0;
      bus.ir_en  = 1'b0;
      bus.bubble = 1'b1;
      bus.DHS    = 1'b0;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (kill) begin
      state_d = ST_RUN;
    end else if (haz) begin
      state_d = ST_STALL;
    end else if (bus.in_valid & (bus.BS != 2'b00)) begin
      state_d = ST_BRANCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // R0 is hardwired, so writes to it never create a dependency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_v <= 1'b0;
      ex_d <= 3'd0;
      wb_v <= 1'b0;
      wb_d <= 3'd0;
    end else begin
      wb_v <= ex_v;
      wb_d <= ex_d;
      ex_v <= bus.in_valid & bus.RW & ~bus.bubble & (bus.DA != 3'd0);
      ex_d <= bus.DA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 8'd0;
      flush_cnt_q <= 8'd0;
    end else if (bus.clr_cnt) begin
      stall_cnt_q <= 8'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      if (haz && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
      if (kill && (flush_cnt_q != 8'hFF)) begin
        flush_cnt_q <= flush_cnt_q + 8'd1;
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
